spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
- Standalone SPI flash read initiator (mode 0, single-bit I/O) for the user project area. It drives the same four-wire flash interface the spiflash model answers on: flash_csb, flash_clk, flash_io0, flash_io1.
- On a start request it issues the standard READ command (0x03) and a 24-bit address. It then streams a programmed number of bytes out through a valid/ready byte port.
- Its typical use is loading crypto key and constant tables from flash into the cryptotop datapath.

Parameters:
- CLK_DIV, 2, flash_clk half-period in clock cycles; legal range ≥1.
- LEN_W, 16, width of the byte-count input.

Ports:
- clock  input  1  system clock.
- resetb  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- addr  input  24  flash start byte address; latched on an accepted start.
- len  input  LEN_W  number of bytes to read; latched on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at the end of a transaction.
- rd_data  output  8  received byte.
- rd_valid  output  1  rd_data holds an unconsumed byte.
- rd_ready  input  1  consumer accepts rd_data when rd_valid && rd_ready.
- flash_csb  output  1  chip select, active low.
- flash_clk  output  1  SPI clock, idles low.
- flash_io0  output  1  MOSI.
- flash_io1  input  1  MISO.

Behaviour:
- Reset (asynchronous, any state, including mid-transfer): flash_csb=1, flash_clk=0, flash_io0=0, busy=0, done=0, rd_valid=0, rd_data=0. The FSM goes to IDLE and all counters clear.
- States:
  - IDLE: default state.
  - SETUP: flash_csb=0 held for one half-period with flash_clk low; MOSI carries the first bit.
  - CMD: 8 bits of 0x03.
  - ADDR: 24 address bits.
  - DATA: len×8 bits.
  - STALL: byte-boundary wait for the holding register to empty.
  - FINISH: flash_csb held low for one more half-period after the last falling edge, then raised.
- Transitions:
  - IDLE→SETUP on start with len≠0.
  - SETUP→CMD→ADDR→DATA→FINISH→IDLE.
  - DATA↔STALL as described below.
- Zero length: start with len=0 never asserts busy and never toggles flash_csb; done pulses the cycle after start.
- start while busy is ignored; addr and len changes while busy are ignored.
- SPI timing:
  - Each flash_clk level lasts exactly CLK_DIV clock cycles.
  - MSB first.
  - flash_io0 changes only while flash_clk is low, updated in the cycle the falling edge is generated, or at SETUP entry for bit 0.
  - flash_io1 is sampled on the cycle flash_clk is driven high (rising edge).
  - flash_io0 is driven 0 during DATA.
- An unstalled transaction takes exactly 32+8·len flash_clk pulses. Pulse count must match exactly: no extra or missing edges.
- Byte output:
  - After the 8th rising edge of each data byte, the byte goes to the holding register and rd_valid=1 on the next cycle.
  - rd_valid stays high and rd_data stays stable until the handshake completes.
  - The handshake completes in the cycle where rd_valid && rd_ready; rd_valid drops on the next cycle unless a new byte loads in that same cycle, in which case it stays high.
- Backpressure:
  - When a new byte completes while rd_valid is still 1, the FSM enters STALL with flash_clk held low and flash_csb held low. The shift register keeps the new byte.
  - On handshake, the new byte moves to the holding register and clocking resumes with the next full low half-period. No byte is ever dropped or duplicated.
- End of transaction:
  - done pulses for one cycle in the same cycle flash_csb returns high; busy falls in that cycle.
  - The final byte may still be pending on rd_valid after done. A new start is accepted only when rd_valid=0 and the FSM is in IDLE.
- Address wrap: no internal address arithmetic; the flash handles wrap past 0xFFFFFF.

Test Plan:
- Power-on: assert resetb=0 for 10 cycles, release → flash_csb=1, flash_clk=0, busy=0, rd_valid=0, with no flash_clk edges over 100 cycles.
- Basic read: CLK_DIV=2, spiflash loaded with bytes 0x00..0xFF, start with addr=0x000010, len=4, rd_ready held 1 → rd_data sequence 0x10,0x11,0x12,0x13. Required counts: exactly 64 flash_clk rising edges, MOSI bits 0x03 0x00 0x00 0x10, one done pulse, flash_csb low for 64×4+4 cycles (pulses plus SETUP and FINISH half-periods).
- Backpressure: addr=0x000000, len=3, rd_ready=0 for 200 cycles after the first rd_valid → flash_clk frozen low after the 2nd byte completes, flash_csb stays 0; releasing rd_ready delivers 0x00,0x01,0x02 in order with no duplicates.
- Zero length and busy start: start with len=0 → done next cycle, flash_csb never low; start pulses mid-transfer → ignored, byte count unchanged.
- Reset mid-operation: deassert resetb during the ADDR phase → flash_csb=1 and flash_clk=0 immediately (asynchronous); a subsequent read of addr=0x000020, len=1 returns 0x20.
- CLK_DIV=1 corner: len=2 at addr 0x0000FE → bytes 0xFE,0xFF with each flash_clk level lasting one cycle.

Source files
------------

// File: rtl/spi_flash_reader.sv
// SPI mode-0 flash READ (0x03) initiator streaming len bytes out on a valid/ready byte port; SPI bit rate is clock/(2*CLK_DIV).
// Backpressure: a byte completing while rd_valid is still set parks flash_clk low at the byte boundary until the holding register drains.
module spi_flash_reader #(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 16
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             flash_csb,
    output logic             flash_clk,
    output logic             flash_io0,
    input  logic             flash_io1
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DATA, S_STALL, S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             pend_q, pend_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             csb_q, csb_d;
    logic             sclk_q, sclk_d;

    logic             tick;
    logic [DIV_W-1:0] div_step;

    assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
    assign div_step = tick ? '0 : div_q + 1'b1;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        pend_d  = pend_q;
        data_d  = data_q;
        valid_d = valid_q && !rd_ready;
        done_d  = 1'b0;
        csb_d   = csb_q;
        sclk_d  = sclk_q;

        // A byte parked in the shift register moves up as soon as the holding register frees.
        if (pend_q && (!valid_q || rd_ready)) begin
            data_d  = rx_q;
            valid_d = 1'b1;
            pend_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (start && !valid_q) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        csb_d   = 1'b0;
                        cnt_d   = len;
                        tx_d    = {8'h03, addr};
                        bit_d   = '0;
                    end
                end
            end
            S_SETUP: begin
                div_d = div_step;
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = S_CMD;
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                div_d = div_step;
                if (tick) begin
                    if (sclk_q) begin
                        // Falling edge: present the next MOSI bit and advance phase counters.
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[30:0], 1'b0};
                        bit_d  = bit_q + 5'd1;
                        if (state_q == S_CMD && bit_q == 5'd7) begin
                            state_d = S_ADDR;
                            bit_d   = '0;
                        end else if (state_q == S_ADDR && bit_q == 5'd23) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                        end else if (state_q == S_DATA && bit_q == 5'd7) begin
                            bit_d = '0;
                            cnt_d = cnt_q - 1'b1;
                        end
                    end else if (state_q == S_DATA && bit_q == 5'd0 && pend_d) begin
                        state_d = S_STALL;
                    end else if (state_q == S_DATA && bit_q == 5'd0 && cnt_q == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        sclk_d = 1'b1;
                        if (state_q == S_DATA) begin
                            rx_d = {rx_q[6:0], flash_io1};
                            if (bit_q == 5'd7) begin
                                if (!valid_q || rd_ready) begin
                                    data_d  = rx_d;
                                    valid_d = 1'b1;
                                end else begin
                                    pend_d = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            S_STALL: begin
                div_d = '0;
                if (!pend_d) begin
                    state_d = (cnt_q == '0) ? S_FINISH : S_DATA;
                end
            end
            S_FINISH: begin
                div_d = div_step;
                if (tick) begin
                    csb_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            csb_q   <= 1'b1;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            csb_q   <= csb_d;
            sclk_q  <= sclk_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign rd_data   = data_q;
    assign rd_valid  = valid_q;
    assign flash_csb = csb_q;
    assign flash_clk = sclk_q;
    assign flash_io0 = tx_q[31];

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: instance 0 at CLK_DIV=2, instance 1 at CLK_DIV=1, each with a flash model holding mem[a]=a[7:0].
module tb_spi_flash_reader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetb = 1'b1;
    logic [1:0]  start  = '0;
    logic [1:0]  rrdy   = '0;
    logic [1:0]  fmiso  = '0;
    logic [1:0]  busy, done, rvld, fcsb, fclk, fmosi;
    logic [23:0] addr [2] = '{24'h0, 24'h0};
    logic [15:0] len  [2] = '{16'h0, 16'h0};
    logic [7:0]  rdat [2];

    spi_flash_reader #(.CLK_DIV(2), .LEN_W(16)) dut0 (
        .clock(clock), .resetb(resetb), .start(start[0]), .addr(addr[0]), .len(len[0]),
        .busy(busy[0]), .done(done[0]), .rd_data(rdat[0]), .rd_valid(rvld[0]), .rd_ready(rrdy[0]),
        .flash_csb(fcsb[0]), .flash_clk(fclk[0]), .flash_io0(fmosi[0]), .flash_io1(fmiso[0])
    );

    spi_flash_reader #(.CLK_DIV(1), .LEN_W(16)) dut1 (
        .clock(clock), .resetb(resetb), .start(start[1]), .addr(addr[1]), .len(len[1]),
        .busy(busy[1]), .done(done[1]), .rd_data(rdat[1]), .rd_valid(rvld[1]), .rd_ready(rrdy[1]),
        .flash_csb(fcsb[1]), .flash_clk(fclk[1]), .flash_io0(fmosi[1]), .flash_io1(fmiso[1])
    );

    // Flash model, edge counters and consumer, all sampled mid-cycle.
    int          rises [2] = '{0, 0};
    int          csbl  [2] = '{0, 0};
    int          dones [2] = '{0, 0};
    int          rxn   [2] = '{0, 0};
    int          bitn  [2] = '{0, 0};
    int          hirun [2] = '{0, 0};
    int          himax [2] = '{0, 0};
    int          viol      = 0;
    logic [31:0] cmdad [2] = '{32'h0, 32'h0};
    logic [7:0]  rxbuf [2][64];
    logic [1:0]  pclk = '0, pvld = '0, phs = '0;
    logic [7:0]  pdat [2] = '{8'h0, 8'h0};

    always @(negedge clock) begin
        int idx, b;
        logic [7:0] v;
        for (int k = 0; k < 2; k++) begin
            if (fcsb[k]) begin
                bitn[k]  = 0;
                fmiso[k] = 1'b0;
            end else if (fclk[k] && !pclk[k]) begin
                rises[k]++;
                if (bitn[k] < 32) cmdad[k] = {cmdad[k][30:0], fmosi[k]};
                else if (fmosi[k]) viol++;
                bitn[k]++;
            end else if (!fclk[k] && pclk[k] && bitn[k] >= 32) begin
                idx = (bitn[k] - 32) / 8;
                b   = 7 - ((bitn[k] - 32) % 8);
                v   = cmdad[k][7:0] + idx[7:0];
                fmiso[k] = v[b];
            end
            if (!fcsb[k]) csbl[k]++;
            if (done[k]) dones[k]++;
            if (fclk[k]) begin
                hirun[k]++;
                if (hirun[k] > himax[k]) himax[k] = hirun[k];
            end else begin
                hirun[k] = 0;
            end
            if (pvld[k] && !phs[k] && (!rvld[k] || rdat[k] != pdat[k])) viol++;
            if (rvld[k] && rrdy[k]) begin
                rxbuf[k][rxn[k] % 64] = rdat[k];
                rxn[k]++;
            end
            pclk[k] = fclk[k];
            pvld[k] = rvld[k];
            phs[k]  = rvld[k] && rrdy[k];
            pdat[k] = rdat[k];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic go(input int k, input logic [23:0] a, input logic [15:0] l);
        @(posedge clock); #1;
        start[k] = 1'b1;
        addr[k]  = a;
        len[k]   = l;
        @(posedge clock); #1;
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int d0, input string nm);
        int n = 0;
        while (dones[k] == d0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk(nm, dones[k] - d0, 1);
        repeat (4) @(negedge clock);
    endtask

    typedef struct {
        logic [23:0] a;
        logic [15:0] l;
        logic [31:0] exp;
        int          nrise;
        int          ncsb;
    } vec_t;

    vec_t tbl [4];
    int   r0, c0, d0, n0, w;
    logic [31:0] e;

    initial begin
        tbl[0] = '{24'h000010, 16'd4, 32'h10111213, 64, 260};
        tbl[1] = '{24'h0000FD, 16'd3, 32'hFDFEFF00, 56, 228};
        tbl[2] = '{24'h0100F0, 16'd1, 32'hF0000000, 40, 164};
        tbl[3] = '{24'hFFFFFF, 16'd2, 32'hFF000000, 48, 196};

        // Power-on reset and idle quiet period.
        #1 resetb = 1'b0;
        repeat (10) @(posedge clock);
        #1 resetb = 1'b1;
        @(negedge clock);
        chk("por_csb", fcsb[0], 1);
        chk("por_clk", fclk[0], 0);
        chk("por_busy", busy[0], 0);
        chk("por_valid", rvld[0], 0);
        chk("por_done", done[0], 0);
        chk("por_data", rdat[0], 0);
        r0 = rises[0]; c0 = csbl[0];
        repeat (100) @(negedge clock);
        chk("por_no_edges", rises[0] - r0, 0);
        chk("por_csb_quiet", csbl[0] - c0, 0);

        // Table-driven reads with rd_ready held high.
        rrdy[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r0 = rises[0]; c0 = csbl[0]; d0 = dones[0]; n0 = rxn[0];
            go(0, tbl[i].a, tbl[i].l);
            wait_done(0, d0, $sformatf("v%0d_done", i));
            chk($sformatf("v%0d_count", i), rxn[0] - n0, {16'h0, tbl[i].l});
            e = tbl[i].exp;
            for (int j = 0; j < int'(tbl[i].l); j++)
                chk($sformatf("v%0d_byte%0d", i, j), rxbuf[0][(n0 + j) % 64], e[31 - 8*j -: 8]);
            chk($sformatf("v%0d_rises", i), rises[0] - r0, tbl[i].nrise);
            chk($sformatf("v%0d_csb_low", i), csbl[0] - c0, tbl[i].ncsb);
            chk($sformatf("v%0d_mosi", i), cmdad[0], {8'h03, tbl[i].a});
        end

        // Zero length: done the cycle after start, chip select untouched.
        c0 = csbl[0]; d0 = dones[0];
        @(posedge clock); #1;
        start[0] = 1'b1; len[0] = 16'd0; addr[0] = 24'h000055;
        @(negedge clock);
        chk("zl_done_early", done[0], 0);
        @(posedge clock); #1;
        start[0] = 1'b0;
        @(negedge clock);
        chk("zl_done", done[0], 1);
        chk("zl_busy", busy[0], 0);
        @(negedge clock);
        chk("zl_done_pulse", done[0], 0);
        repeat (20) @(negedge clock);
        chk("zl_csb_quiet", csbl[0] - c0, 0);
        chk("zl_done_count", dones[0] - d0, 1);

        // Start while busy is ignored.
        r0 = rises[0]; d0 = dones[0]; n0 = rxn[0];
        go(0, 24'h000010, 16'd2);
        repeat (60) @(posedge clock);
        #1 start[0] = 1'b1; addr[0] = 24'h000080; len[0] = 16'd5;
        @(posedge clock); #1 start[0] = 1'b0;
        wait_done(0, d0, "bs_done");
        chk("bs_count", rxn[0] - n0, 2);
        chk("bs_byte0", rxbuf[0][n0 % 64], 8'h10);
        chk("bs_byte1", rxbuf[0][(n0 + 1) % 64], 8'h11);
        chk("bs_rises", rises[0] - r0, 48);
        chk("bs_mosi", cmdad[0], 32'h03000010);

        // Backpressure: clock parks low after byte 2 until the consumer drains.
        rrdy[0] = 1'b0;
        r0 = rises[0]; d0 = dones[0]; n0 = rxn[0];
        go(0, 24'h000000, 16'd3);
        w = 0;
        while (!rvld[0] && w < 1000) begin
            @(negedge clock);
            w++;
        end
        chk("bp_first_valid", rvld[0], 1);
        repeat (200) @(negedge clock);
        chk("bp_clk_low", fclk[0], 0);
        chk("bp_csb_low", fcsb[0], 0);
        chk("bp_busy", busy[0], 1);
        chk("bp_frozen_rises", rises[0] - r0, 48);
        chk("bp_hold_data", rdat[0], 8'h00);
        @(posedge clock); #1 rrdy[0] = 1'b1;
        wait_done(0, d0, "bp_done");
        chk("bp_count", rxn[0] - n0, 3);
        chk("bp_byte0", rxbuf[0][n0 % 64], 8'h00);
        chk("bp_byte1", rxbuf[0][(n0 + 1) % 64], 8'h01);
        chk("bp_byte2", rxbuf[0][(n0 + 2) % 64], 8'h02);
        chk("bp_rises", rises[0] - r0, 56);

        // Asynchronous reset during the address phase, then a clean read.
        r0 = rises[0];
        go(0, 24'h000040, 16'd2);
        w = 0;
        while (rises[0] - r0 < 20 && w < 500) begin
            @(negedge clock);
            w++;
        end
        #2 resetb = 1'b0;
        #1;
        chk("rst_csb", fcsb[0], 1);
        chk("rst_clk", fclk[0], 0);
        chk("rst_busy", busy[0], 0);
        repeat (3) @(posedge clock);
        #1 resetb = 1'b1;
        r0 = rises[0]; d0 = dones[0]; n0 = rxn[0];
        go(0, 24'h000020, 16'd1);
        wait_done(0, d0, "rst_done");
        chk("rst_count", rxn[0] - n0, 1);
        chk("rst_byte0", rxbuf[0][n0 % 64], 8'h20);
        chk("rst_rises", rises[0] - r0, 40);

        // CLK_DIV=1 instance: every flash_clk level lasts a single cycle.
        rrdy[1] = 1'b1;
        r0 = rises[1]; c0 = csbl[1]; d0 = dones[1]; n0 = rxn[1];
        go(1, 24'h0000FE, 16'd2);
        wait_done(1, d0, "d1_done");
        chk("d1_count", rxn[1] - n0, 2);
        chk("d1_byte0", rxbuf[1][n0 % 64], 8'hFE);
        chk("d1_byte1", rxbuf[1][(n0 + 1) % 64], 8'hFF);
        chk("d1_rises", rises[1] - r0, 48);
        chk("d1_csb_low", csbl[1] - c0, 98);
        chk("d1_high_len", himax[1], 1);

        chk("d2_high_len", himax[0], 2);
        chk("protocol_violations", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
